// File: rtl/anc_pkg.sv
// Shared constants for the ANC filter datapath: operand/product widths and
// the fixed requester IDs used when wiring clients onto the shared multiplier.
package anc_pkg;

  // Operand width of the shared multiplier and the full product width.
  localparam int DW = 10;
  localparam int PW = 2 * DW;

  // Requester slots on the multiplier arbiter.
  localparam int REQ_FIR = 0;  // FIR tap MACs
  localparam int REQ_LMS = 1;  // LMS weight update
  localparam int REQ_ERR = 2;  // error scaling
  localparam int REQ_AUX = 3;  // spare / auxiliary

endpackage

// File: rtl/mul_arbiter_if.sv
// Requester-side bus of the multiplier arbiter: per-requester operand
// handshake in, tagged one-hot product strobe out.
interface mul_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = anc_pkg::DW
) ();

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_last;
  logic [NREQ*DW-1:0] req_a;
  logic [NREQ*DW-1:0] req_b;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    rsp_valid;
  logic [2*DW-1:0]    rsp_data;

  // Requester cluster drives operands and consumes grants/results.
  modport master (
    output req_valid, req_last, req_a, req_b,
    input  req_ready, rsp_valid, rsp_data
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_last, req_a, req_b,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first set bit of `valid` found by
// scanning upward from ptr+1 (wrapping modulo NREQ) wins. The requester at
// `ptr` itself is considered last, which gives it lowest priority next round.
module rr_pick #(
  parameter  int NREQ = 4,
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            any
);

  logic [IW-1:0] pos;

  // Rotating priority scan; only the first hit is kept.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      pos = IW'((int'(ptr) + k) % NREQ);
      if (!any && valid[pos]) begin
        any        = 1'b1;
        grant[pos] = 1'b1;
        idx        = pos;
      end
    end
  end

endmodule

// File: rtl/mul_arbiter.sv
// Round-robin arbiter and two-stage sequencer for the shared multiplier.
// Beats are issued into registered operands (mul_a/mul_b), the product from
// the external combinational multiplier is captured one cycle later and
// returned to the originating requester as a one-cycle one-hot strobe.
// A beat with last=0 locks the grant to its requester until last=1.
module mul_arbiter #(
  parameter  int NREQ = 4,
  parameter  int DW   = anc_pkg::DW,
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int PW   = 2 * DW
) (
  input  logic          clk,
  input  logic          rst_n,
  mul_arbiter_if.slave  bus,
  output logic [DW-1:0] mul_a,
  output logic [DW-1:0] mul_b,
  input  logic [PW-1:0] mul_p,
  output logic          busy
);

  // Grant FSM: IDLE arbitrates round-robin, LOCKED pins the grant on owner.
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]      state;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   ptr;

  logic [NREQ-1:0] pick_grant;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;

  logic [NREQ-1:0] ready_vec;
  logic [IW-1:0]   sel;
  logic            sel_last;
  logic            xfer;

  logic [DW-1:0]   a_arr [NREQ];
  logic [DW-1:0]   b_arr [NREQ];

  logic            vld_p1;
  logic [IW-1:0]   tag_p1;
  logic            vld_p2;
  logic [IW-1:0]   tag_p2;
  logic [PW-1:0]   data_p2;

  // Unpack the flat operand buses once so selection uses a plain array index.
  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign a_arr[g] = bus.req_a[g*DW +: DW];
    assign b_arr[g] = bus.req_b[g*DW +: DW];
  end

  rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .valid (bus.req_valid),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Grant vector: the picker's choice, overridden by the owner while locked
  // (held even across gaps where the owner drops valid).
  always_comb begin
    ready_vec = pick_grant;
    if (state == ST_LOCKED) begin
      ready_vec        = '0;
      ready_vec[owner] = 1'b1;
    end
  end

  assign bus.req_ready = ready_vec;
  assign sel           = (state == ST_LOCKED) ? owner : pick_idx;
  assign xfer          = (state == ST_LOCKED) ? bus.req_valid[owner] : pick_any;
  assign sel_last      = bus.req_last[sel];

  // Lock/owner/pointer update on every accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      owner <= '0;
      ptr   <= IW'(NREQ - 1);
    end else if (xfer) begin
      ptr <= sel;
      if (sel_last) begin
        state <= ST_IDLE;
      end else begin
        state <= ST_LOCKED;
        owner <= sel;
      end
    end
  end

  // ---- stage p0 -> p1: register operands and tag of the accepted beat ----
  // Operands hold their last issued value while no beat is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      tag_p1 <= '0;
      mul_a  <= '0;
      mul_b  <= '0;
    end else begin
      vld_p1 <= xfer;
      if (xfer) begin
        tag_p1 <= sel;
        mul_a  <= a_arr[sel];
        mul_b  <= b_arr[sel];
      end
    end
  end

  // ---- stage p1 -> p2: capture the settled product with its tag ----
  // The product passes through untouched; signedness is the multiplier's.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2  <= 1'b0;
      tag_p2  <= '0;
      data_p2 <= '0;
    end else begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        tag_p2  <= tag_p1;
        data_p2 <= mul_p;
      end
    end
  end

  // ---- stage p2 output: one-hot strobe back to the originating requester ----
  always_comb begin
    bus.rsp_valid = '0;
    if (vld_p2) begin
      bus.rsp_valid[tag_p2] = 1'b1;
    end
  end

  assign bus.rsp_data = data_p2;
  assign busy         = (state == ST_LOCKED) | vld_p1 | vld_p2;

endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench for mul_arbiter. Requesters are modelled as per-slot
// beat queues; a reference model tracks lock/pointer and expected results.
module tb_mul_arbiter;
  import anc_pkg::*;

  localparam int NREQ = 4;

  typedef struct {
    int a;
    int b;
    bit last;
    bit gap;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mul_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

  logic [DW-1:0]   mul_a, mul_b;
  logic [PW-1:0]   mul_p;
  logic            busy;
  logic [NREQ-1:0] valid, last;
  logic [DW-1:0]   opa [NREQ];
  logic [DW-1:0]   opb [NREQ];

  assign bus.req_valid = valid;
  assign bus.req_last  = last;
  always_comb begin
    bus.req_a = '0;
    bus.req_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_a[i*DW +: DW] = opa[i];
      bus.req_b[i*DW +: DW] = opb[i];
    end
  end

  // External unsigned multiplier.
  assign mul_p = PW'(mul_a) * PW'(mul_b);

  mul_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .mul_a (mul_a),
    .mul_b (mul_b),
    .mul_p (mul_p),
    .busy  (busy)
  );

  // Reference model state.
  int            cyc, checks, passes, fails;
  bit            m_locked;
  int            m_owner, m_ptr;
  int            q_due [$];
  int            q_tag [$];
  logic [PW-1:0] q_val [$];
  int            glog [$];
  beat_t         bq [NREQ][$];
  logic [DW-1:0] m_last_a, m_last_b;

  logic [NREQ-1:0] er, ev;
  logic [PW-1:0]   ed;
  logic            eb;

  function automatic logic [NREQ-1:0] model_ready();
    logic [NREQ-1:0] r = '0;
    if (m_locked) r[m_owner] = 1'b1;
    else begin
      for (int k = 1; k <= NREQ; k++) begin
        int i = (m_ptr + k) % NREQ;
        if (valid[i]) begin
          r[i] = 1'b1;
          break;
        end
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    m_locked = 1'b0;
    m_owner  = 0;
    m_ptr    = NREQ - 1;
    q_due.delete();
    q_tag.delete();
    q_val.delete();
    for (int i = 0; i < NREQ; i++) bq[i].delete();
    m_last_a = '0;
    m_last_b = '0;
  endtask

  task automatic push(input int r, input int a, input int b, input bit l, input bit g);
    beat_t bt;
    bt.a = a; bt.b = b; bt.last = l; bt.gap = g;
    bq[r].push_back(bt);
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      if (bq[i].size() > 0 && !bq[i][0].gap) begin
        valid[i] = 1'b1;
        last[i]  = bq[i][0].last;
        opa[i]   = DW'(bq[i][0].a);
        opb[i]   = DW'(bq[i][0].b);
      end else begin
        valid[i] = 1'b0;
        last[i]  = 1'b0;
      end
    end
  endtask

  // Expected outputs for the current cycle; also logs the DUT's grants.
  task automatic sample(output logic [NREQ-1:0] xr, output logic [NREQ-1:0] xv,
                        output logic [PW-1:0] xd, output logic xb);
    @(negedge clk);
    xr = model_ready();
    xv = '0;
    xd = '0;
    if (q_due.size() > 0 && q_due[0] == cyc) begin
      xv[q_tag[0]] = 1'b1;
      xd = q_val[0];
    end
    xb = m_locked || (q_due.size() > 0);
    for (int i = 0; i < NREQ; i++)
      if (valid[i] && bus.req_ready[i]) glog.push_back(i);
  endtask

  // Apply the spec rules for this cycle's transfer, then step to the next cycle.
  task automatic advance(input logic [NREQ-1:0] xr);
    if (q_due.size() > 0 && q_due[0] == cyc) begin
      void'(q_due.pop_front());
      void'(q_tag.pop_front());
      void'(q_val.pop_front());
    end
    for (int i = 0; i < NREQ; i++) begin
      if (valid[i] && xr[i]) begin
        int pa = int'(opa[i]);
        int pb = int'(opb[i]);
        q_due.push_back(cyc + 2);
        q_tag.push_back(i);
        q_val.push_back(PW'(pa * pb));
        m_ptr    = i;
        m_last_a = opa[i];
        m_last_b = opb[i];
        if (last[i]) m_locked = 1'b0;
        else begin
          m_locked = 1'b1;
          m_owner  = i;
        end
        void'(bq[i].pop_front());
      end else if (bq[i].size() > 0 && bq[i][0].gap) begin
        void'(bq[i].pop_front());
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    drive();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    cyc++;
    #1;
    drive();
  endtask

  task automatic test_reset();
    model_reset();
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.req_ready !== '0) begin fails++; $display("FAIL reset ready got=%b want=0", bus.req_ready); end else passes++;
    checks++; if (bus.rsp_valid !== '0) begin fails++; $display("FAIL reset rsp_valid got=%b want=0", bus.rsp_valid); end else passes++;
    checks++; if (bus.rsp_data !== '0) begin fails++; $display("FAIL reset rsp_data got=%0d want=0", bus.rsp_data); end else passes++;
    checks++; if (mul_a !== '0 || mul_b !== '0) begin fails++; $display("FAIL reset mul_ab got=%0d,%0d want=0,0", mul_a, mul_b); end else passes++;
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset busy got=%b want=0", busy); end else passes++;
    rst_n = 1'b1;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic test_single();
    push(REQ_FIR, 20, 23, 1'b1, 1'b0);
    drive();
    for (int c = 0; c < 6; c++) begin
      sample(er, ev, ed, eb);
      if (c == 0) begin
        checks++; if (bus.req_ready !== 4'b0001) begin fails++; $display("FAIL single first_grant got=%b want=0001", bus.req_ready); end else passes++;
      end
      checks++; if (bus.req_ready !== er) begin fails++; $display("FAIL single ready cyc=%0d got=%b want=%b", cyc, bus.req_ready, er); end else passes++;
      checks++; if (bus.rsp_valid !== ev) begin fails++; $display("FAIL single rsp_valid cyc=%0d got=%b want=%b", cyc, bus.rsp_valid, ev); end else passes++;
      if (ev != '0) begin
        checks++; if (bus.rsp_data !== ed) begin fails++; $display("FAIL single rsp_data cyc=%0d got=%0d want=%0d", cyc, bus.rsp_data, ed); end else passes++;
      end
      checks++; if (busy !== eb) begin fails++; $display("FAIL single busy cyc=%0d got=%b want=%b", cyc, busy, eb); end else passes++;
      advance(er);
    end
  endtask

  task automatic test_contention();
    apply_reset();
    glog.delete();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NREQ; i++) push(i, i + 1, 3, 1'b1, 1'b0);
    drive();
    for (int c = 0; c < 12; c++) begin
      sample(er, ev, ed, eb);
      checks++; if (bus.req_ready !== er) begin fails++; $display("FAIL contention ready cyc=%0d got=%b want=%b", cyc, bus.req_ready, er); end else passes++;
      checks++; if (bus.rsp_valid !== ev) begin fails++; $display("FAIL contention rsp_valid cyc=%0d got=%b want=%b", cyc, bus.rsp_valid, ev); end else passes++;
      if (ev != '0) begin
        checks++; if (bus.rsp_data !== ed) begin fails++; $display("FAIL contention rsp_data cyc=%0d got=%0d want=%0d", cyc, bus.rsp_data, ed); end else passes++;
      end
      checks++; if (busy !== eb) begin fails++; $display("FAIL contention busy cyc=%0d got=%b want=%b", cyc, busy, eb); end else passes++;
      advance(er);
    end
    checks++; if (glog.size() !== 8) begin fails++; $display("FAIL contention grant_count got=%0d want=8", glog.size()); end
    else begin
      passes++;
      for (int k = 0; k < 8; k++) begin
        checks++; if (glog[k] !== k % NREQ) begin fails++; $display("FAIL contention order[%0d] got=%0d want=%0d", k, glog[k], k % NREQ); end else passes++;
      end
    end
  endtask

  task automatic test_burst();
    glog.delete();
    push(REQ_LMS, 5, 10, 1'b0, 1'b0);
    push(REQ_LMS, 6, 10, 1'b0, 1'b0);
    push(REQ_LMS, 0, 0, 1'b0, 1'b1);
    push(REQ_LMS, 7, 10, 1'b0, 1'b0);
    push(REQ_LMS, 8, 10, 1'b1, 1'b0);
    push(REQ_ERR, 7, 9, 1'b1, 1'b0);
    drive();
    for (int c = 0; c < 10; c++) begin
      sample(er, ev, ed, eb);
      checks++; if (bus.req_ready !== er) begin fails++; $display("FAIL burst ready cyc=%0d got=%b want=%b", cyc, bus.req_ready, er); end else passes++;
      checks++; if (bus.rsp_valid !== ev) begin fails++; $display("FAIL burst rsp_valid cyc=%0d got=%b want=%b", cyc, bus.rsp_valid, ev); end else passes++;
      if (ev != '0) begin
        checks++; if (bus.rsp_data !== ed) begin fails++; $display("FAIL burst rsp_data cyc=%0d got=%0d want=%0d", cyc, bus.rsp_data, ed); end else passes++;
      end
      checks++; if (busy !== eb) begin fails++; $display("FAIL burst busy cyc=%0d got=%b want=%b", cyc, busy, eb); end else passes++;
      advance(er);
    end
    checks++; if (glog.size() !== 5) begin fails++; $display("FAIL burst grant_count got=%0d want=5", glog.size()); end
    else begin
      passes++;
      checks++; if (glog[4] !== REQ_ERR || glog[3] !== REQ_LMS) begin fails++; $display("FAIL burst order got=%0d,%0d want=1,2", glog[3], glog[4]); end else passes++;
    end
  endtask

  task automatic test_boundary();
    push(REQ_AUX, 1023, 1023, 1'b1, 1'b0);
    push(REQ_FIR, 0, 1023, 1'b1, 1'b0);
    drive();
    for (int c = 0; c < 6; c++) begin
      sample(er, ev, ed, eb);
      checks++; if (bus.req_ready !== er) begin fails++; $display("FAIL boundary ready cyc=%0d got=%b want=%b", cyc, bus.req_ready, er); end else passes++;
      checks++; if (bus.rsp_valid !== ev) begin fails++; $display("FAIL boundary rsp_valid cyc=%0d got=%b want=%b", cyc, bus.rsp_valid, ev); end else passes++;
      if (ev != '0) begin
        checks++; if (bus.rsp_data !== ed) begin fails++; $display("FAIL boundary rsp_data cyc=%0d got=%0d want=%0d", cyc, bus.rsp_data, ed); end else passes++;
      end
      checks++; if (busy !== eb) begin fails++; $display("FAIL boundary busy cyc=%0d got=%b want=%b", cyc, busy, eb); end else passes++;
      advance(er);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < NREQ; i++) begin
      int nb = int'($urandom_range(1, 3));
      for (int n = 0; n < nb; n++) begin
        int len = int'($urandom_range(1, 4));
        for (int j = 0; j < len; j++) begin
          push(i, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), (j == len - 1), 1'b0);
          if ($urandom_range(0, 3) == 0) push(i, 0, 0, 1'b0, 1'b1);
        end
      end
    end
    drive();
    for (int c = 0; c < 200; c++) begin
      sample(er, ev, ed, eb);
      checks++; if (bus.req_ready !== er) begin fails++; $display("FAIL random ready cyc=%0d got=%b want=%b", cyc, bus.req_ready, er); end else passes++;
      checks++; if (bus.rsp_valid !== ev) begin fails++; $display("FAIL random rsp_valid cyc=%0d got=%b want=%b", cyc, bus.rsp_valid, ev); end else passes++;
      if (ev != '0) begin
        checks++; if (bus.rsp_data !== ed) begin fails++; $display("FAIL random rsp_data cyc=%0d got=%0d want=%0d", cyc, bus.rsp_data, ed); end else passes++;
      end
      checks++; if (busy !== eb) begin fails++; $display("FAIL random busy cyc=%0d got=%b want=%b", cyc, busy, eb); end else passes++;
      advance(er);
    end
  endtask

  task automatic test_reset_mid();
    push(REQ_ERR, 11, 12, 1'b0, 1'b0);
    push(REQ_ERR, 13, 14, 1'b0, 1'b0);
    push(REQ_ERR, 15, 16, 1'b1, 1'b0);
    drive();
    for (int c = 0; c < 2; c++) begin
      sample(er, ev, ed, eb);
      checks++; if (bus.req_ready !== er) begin fails++; $display("FAIL rstmid ready cyc=%0d got=%b want=%b", cyc, bus.req_ready, er); end else passes++;
      advance(er);
    end
    rst_n = 1'b0;
    model_reset();
    drive();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++; if (bus.rsp_valid !== '0) begin fails++; $display("FAIL rstmid rsp_valid c=%0d got=%b want=0", c, bus.rsp_valid); end else passes++;
      checks++; if (bus.req_ready !== '0 || busy !== 1'b0) begin fails++; $display("FAIL rstmid ready_busy got=%b,%b want=0,0", bus.req_ready, busy); end else passes++;
      checks++; if (mul_a !== '0 || mul_b !== '0 || bus.rsp_data !== '0) begin fails++; $display("FAIL rstmid data got=%0d,%0d,%0d want=0,0,0", mul_a, mul_b, bus.rsp_data); end else passes++;
      if (c == 0) @(posedge clk);
    end
    rst_n = 1'b1;
    @(posedge clk);
    cyc++;
    #1;
    glog.delete();
    push(REQ_AUX, 1, 2, 1'b1, 1'b0);
    push(REQ_FIR, 3, 4, 1'b1, 1'b0);
    drive();
    for (int c = 0; c < 6; c++) begin
      sample(er, ev, ed, eb);
      checks++; if (bus.req_ready !== er) begin fails++; $display("FAIL rstmid ready cyc=%0d got=%b want=%b", cyc, bus.req_ready, er); end else passes++;
      checks++; if (bus.rsp_valid !== ev) begin fails++; $display("FAIL rstmid rsp_valid cyc=%0d got=%b want=%b", cyc, bus.rsp_valid, ev); end else passes++;
      if (ev != '0) begin
        checks++; if (bus.rsp_data !== ed) begin fails++; $display("FAIL rstmid rsp_data cyc=%0d got=%0d want=%0d", cyc, bus.rsp_data, ed); end else passes++;
      end
      checks++; if (busy !== eb) begin fails++; $display("FAIL rstmid busy cyc=%0d got=%b want=%b", cyc, busy, eb); end else passes++;
      advance(er);
    end
    checks++; if (glog.size() < 1) begin fails++; $display("FAIL rstmid first_grant got=none want=0"); end
    else if (glog[0] !== REQ_FIR) begin fails++; $display("FAIL rstmid first_grant got=%0d want=0", glog[0]); end
    else passes++;
  endtask

  task automatic test_idle_hold();
    drive();
    for (int c = 0; c < 10; c++) begin
      sample(er, ev, ed, eb);
      checks++; if (bus.req_ready !== er || er !== '0) begin fails++; $display("FAIL idle ready cyc=%0d got=%b want=0", cyc, bus.req_ready); end else passes++;
      checks++; if (bus.rsp_valid !== ev) begin fails++; $display("FAIL idle rsp_valid cyc=%0d got=%b want=%b", cyc, bus.rsp_valid, ev); end else passes++;
      checks++; if (busy !== eb) begin fails++; $display("FAIL idle busy cyc=%0d got=%b want=%b", cyc, busy, eb); end else passes++;
      checks++; if (mul_a !== m_last_a || mul_b !== m_last_b) begin fails++; $display("FAIL idle mul_hold got=%0d,%0d want=%0d,%0d", mul_a, mul_b, m_last_a, m_last_b); end else passes++;
      advance(er);
    end
  endtask

  initial begin
    cyc = 0; checks = 0; passes = 0; fails = 0;
    valid = '0; last = '0;
    for (int i = 0; i < NREQ; i++) begin
      opa[i] = '0;
      opb[i] = '0;
    end
    test_reset();
    test_single();
    test_contention();
    test_burst();
    test_boundary();
    test_random();
    test_reset_mid();
    test_idle_hold();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
